// File: rtl/puf_resp_gen_if.sv
// Request/result bundle between the ring-oscillator PUF response generator and its requester.
interface puf_resp_gen_if #(
    parameter int RESP_BITS = 8
);
    logic                 start;
    logic [4:0]           base_chal;
    logic [4:0]           chal_out;
    logic                 busy;
    logic                 done;
    logic                 resp_valid;
    logic [RESP_BITS-1:0] response;
    logic [5:0]           tie_cnt;

    modport master (
        output start, base_chal,
        input  chal_out, busy, done, resp_valid, response, tie_cnt
    );

    modport slave (
        input  start, base_chal,
        output chal_out, busy, done, resp_valid, response, tie_cnt
    );
endinterface

// File: rtl/puf_resp_gen.sv
// Ring-oscillator PUF response generator: steps challenges, counts synchronized RO edges, compares.
// Optional PUF_MAJORITY_EN: three measurements per challenge, response bit is their majority.
module puf_resp_gen #(
    parameter int WINDOW_CYCLES = 1024,
    parameter int CNT_W         = 16,
    parameter int RESP_BITS     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ro_a,
    input  logic          ro_b,
    puf_resp_gen_if.slave bus
);
    localparam int               TMR_W       = $clog2(WINDOW_CYCLES);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(3);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [4:0]       LAST_IDX    = 5'(RESP_BITS - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, COMPARE, DONE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           sync_a, sync_b;
    logic                 edge_a, edge_b;
    logic [CNT_W-1:0]     cnt_a, cnt_b;
    logic [TMR_W-1:0]     timer_q;
    logic [4:0]           idx_q, base_q, chal_q;
    logic                 busy_q, done_q, valid_q;
    logic [RESP_BITS-1:0] resp_q;
    logic [5:0]           tie_q;
    logic                 a_gt_b, a_eq_b, last_pass, last_bit;
    logic                 bit_result, bit_tie, accept;

    assign edge_a   = sync_a[1] & ~sync_a[2];
    assign edge_b   = sync_b[1] & ~sync_b[2];
    assign a_gt_b   = cnt_a > cnt_b;
    assign a_eq_b   = cnt_a == cnt_b;
    assign last_bit = idx_q == LAST_IDX;
    assign accept   = (state_q == IDLE) && bus.start;

`ifdef PUF_MAJORITY_EN
    logic [1:0] pass_q;
    logic [1:0] votes_q;
    logic       tie_seen_q;

    assign last_pass  = pass_q == 2'd2;
    assign bit_result = (votes_q[0] & votes_q[1]) | (votes_q[0] & a_gt_b) | (votes_q[1] & a_gt_b);
    assign bit_tie    = tie_seen_q | a_eq_b;

    // The first two votes are stored; the third is combined live in the final COMPARE.
    always_ff @(posedge clk) begin
        if (!rst_n || accept) begin
            pass_q     <= 2'd0;
            votes_q    <= 2'b00;
            tie_seen_q <= 1'b0;
        end else if (state_q == COMPARE) begin
            if (last_pass) begin
                pass_q     <= 2'd0;
                tie_seen_q <= 1'b0;
            end else begin
                pass_q     <= pass_q + 2'd1;
                tie_seen_q <= tie_seen_q | a_eq_b;
                if (pass_q == 2'd0) votes_q[0] <= a_gt_b;
                else                votes_q[1] <= a_gt_b;
            end
        end
    end
`else
    assign last_pass  = 1'b1;
    assign bit_result = a_gt_b;
    assign bit_tie    = a_eq_b;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SETTLE;
            SETTLE:  if (timer_q == SETTLE_LAST) state_d = MEASURE;
            MEASURE: if (timer_q == WINDOW_LAST) state_d = COMPARE;
            COMPARE: state_d = (last_pass && last_bit) ? DONE : SETTLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Third flop per oscillator exists only to detect the rising edge in the clk domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a <= 3'b000;
            sync_b <= 3'b000;
        end else begin
            sync_a <= {sync_a[1:0], ro_a};
            sync_b <= {sync_b[1:0], ro_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q <= '0;
            cnt_a   <= '0;
            cnt_b   <= '0;
            idx_q   <= 5'd0;
            base_q  <= 5'd0;
            chal_q  <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            resp_q  <= '0;
            tie_q   <= 6'd0;
        end else begin
            timer_q <= (state_d != state_q) ? '0 : timer_q + TMR_W'(1);
            done_q  <= state_d == DONE;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        base_q  <= bus.base_chal;
                        chal_q  <= bus.base_chal;
                        idx_q   <= 5'd0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        resp_q  <= '0;
                        tie_q   <= 6'd0;
                    end
                end
                SETTLE: begin
                    cnt_a <= '0;
                    cnt_b <= '0;
                end
                MEASURE: begin
                    if (edge_a && (cnt_a != '1)) cnt_a <= cnt_a + CNT_W'(1);
                    if (edge_b && (cnt_b != '1)) cnt_b <= cnt_b + CNT_W'(1);
                end
                COMPARE: begin
                    if (last_pass) begin
                        resp_q <= resp_q | (RESP_BITS'(bit_result) << idx_q);
                        if (bit_tie) tie_q <= tie_q + 6'd1;
                        if (last_bit) begin
                            valid_q <= 1'b1;
                        end else begin
                            idx_q  <= idx_q + 5'd1;
                            chal_q <= base_q + idx_q + 5'd1;
                        end
                    end
                end
                DONE: busy_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.chal_out   = chal_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.resp_valid = valid_q;
    assign bus.response   = resp_q;
    assign bus.tie_cnt    = tie_q;

endmodule

// File: tb/tb_puf_resp_gen.sv
// Randomized bench for puf_resp_gen: oscillators modelled by period tables, results predicted from rates.
module tb_puf_resp_gen;
    localparam int W    = 64;
    localparam int R    = 8;
`ifdef PUF_MAJORITY_EN
    localparam int P       = 3;
    localparam int LAT_LIT = 1657;
`else
    localparam int P       = 1;
    localparam int LAT_LIT = 553;
`endif
    localparam int SLOT = W + 5;
    localparam int RUN  = R * P * SLOT;
    localparam int LAT  = RUN + 1;

    typedef logic [4:0] seq_t [8];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ro_a  = 1'b0;
    logic ro_b  = 1'b0;

    puf_resp_gen_if #(.RESP_BITS(R)) dif ();

    puf_resp_gen #(.WINDOW_CYCLES(W), .CNT_W(16), .RESP_BITS(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ro_a  (ro_a),
        .ro_b  (ro_b),
        .bus   (dif.slave)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Oscillator periods in clk cycles per challenge; 0 means a static (non-toggling) input.
    int pa [32];
    int pb [32];
    bit mid_b_fast = 1'b0;

    int           cyc = 0;
    bit           m_init = 1'b0, m_run = 1'b0;
    int           m_e = 0, m_s = 0;
    logic [4:0]   m_base = 5'd0, m_chal = 5'd0;
    bit           m_busy = 1'b0, m_done = 1'b0, m_valid = 1'b0;
    logic [R-1:0] m_resp = '0, exp_resp = '0;
    logic [5:0]   m_tie = 6'd0, exp_tie = 6'd0;
    logic [4:0]   chal_seq [$];
    bit           rec_seq = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int per_a(input int chal);
        return pa[chal];
    endfunction

    function automatic int per_b(input int chal, input int slot);
        if (mid_b_fast && (P == 3) && ((slot % 3) == 1)) return 6;
        return pb[chal];
    endfunction

    // Faster oscillator (shorter period) wins; equal rates (both static) are ties.
    function automatic void predict(input logic [4:0] base);
        exp_resp = '0;
        exp_tie  = 6'd0;
        for (int k = 0; k < R; k++) begin
            int  chal = (int'(base) + k) % 32;
            int  votes = 0;
            bit  tied = 1'b0;
            for (int p = 0; p < P; p++) begin
                int a = per_a(chal);
                int b = per_b(chal, k * P + p);
                if (a == b) tied = 1'b1;
                else if (a != 0 && (b == 0 || a < b)) votes++;
            end
            if (votes * 2 > P) exp_resp[k] = 1'b1;
            if (tied) exp_tie = exp_tie + 6'd1;
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_init = 1'b1; m_run = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            m_valid = 1'b0; m_resp = '0; m_tie = 6'd0; m_chal = 5'd0;
        end else if (m_run) begin
            m_e++;
            if (m_e < RUN) begin
                m_chal = m_base + 5'(m_e / (P * SLOT));
            end else if (m_e == RUN) begin
                m_done = 1'b1; m_valid = 1'b1; m_resp = exp_resp; m_tie = exp_tie;
            end else begin
                m_run = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            end
        end else if (dif.start === 1'b1) begin
            m_run = 1'b1; m_e = 0; m_s = cyc; m_busy = 1'b1; m_valid = 1'b0;
            m_resp = '0; m_tie = 6'd0; m_base = dif.base_chal; m_chal = dif.base_chal;
            predict(dif.base_chal);
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            checkOutput("busy", dif.busy, m_busy);
            checkOutput("done", dif.done, m_done);
            checkOutput("resp_valid", dif.resp_valid, m_valid);
            checkOutput("chal_out", dif.chal_out, m_chal);
            if (m_valid || !m_busy) begin
                checkOutput("response", dif.response, m_resp);
                checkOutput("tie_cnt", dif.tie_cnt, m_tie);
            end
            if (rec_seq && dif.busy === 1'b1 && (chal_seq.size() == 0 || chal_seq[$] != dif.chal_out))
                chal_seq.push_back(dif.chal_out);
        end
    end

    // Oscillators step on odd time units so their edges never coincide with clk edges.
    initial begin
        int ph = 0, lastp = -1, p;
        #1;
        forever begin
            #2;
            p = per_a(int'(dif.chal_out));
            if (p != lastp) begin ph = 0; lastp = p; end
            if (p == 0) ro_a = 1'b0;
            else begin
                ph++;
                if (ph >= p * 5) begin ph = 0; ro_a = ~ro_a; end
            end
        end
    end

    initial begin
        int ph = 0, lastp = -1, p;
        #3;
        forever begin
            #2;
            p = per_b(int'(dif.chal_out), m_run ? m_e / SLOT : 0);
            if (p != lastp) begin ph = 0; lastp = p; end
            if (p == 0) ro_b = 1'b0;
            else begin
                ph++;
                if (ph >= p * 5) begin ph = 0; ro_b = ~ro_b; end
            end
        end
    end

    task automatic applyStimulus(input bit s, input logic [4:0] b);
        @(negedge clk);
        dif.start     = s;
        dif.base_chal = b;
        @(negedge clk);
        dif.start     = 1'b0;
        dif.base_chal = 5'($urandom);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (dif.done !== 1'b1 && n < LAT + 20) begin
            @(negedge clk);
            n++;
        end
        if (dif.done === 1'b1) checkOutput({name, "_latency"}, cyc - m_s + 1, LAT_LIT);
        else                   checkOutput({name, "_timeout"}, 0, 1);
    endtask

    task automatic run_case(input string name, input logic [4:0] base, input bit pin,
                            input logic [R-1:0] lit_resp, input logic [5:0] lit_tie);
        chal_seq.delete();
        rec_seq = 1'b1;
        applyStimulus(1'b1, base);
        wait_done(name);
        rec_seq = 1'b0;
        if (pin) begin
            @(negedge clk);
            checkOutput({name, "_resp"}, dif.response, lit_resp);
            checkOutput({name, "_tie"}, dif.tie_cnt, lit_tie);
            checkOutput({name, "_valid"}, dif.resp_valid, 1);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_seq(input string name, input seq_t exp);
        checkOutput({name, "_seq_len"}, chal_seq.size(), 8);
        for (int i = 0; i < 8 && i < chal_seq.size(); i++)
            checkOutput({name, "_seq"}, chal_seq[i], exp[i]);
    endtask

    task automatic fill(input int a, input int b);
        for (int c = 0; c < 32; c++) begin pa[c] = a; pb[c] = b; end
    endtask

    initial begin
        seq_t seq0  = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
        seq_t seq31 = '{5'd31, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
        int   opts [4] = '{0, 6, 12, 24};
        int   nd;

        dif.start     = 1'b0;
        dif.base_chal = 5'd0;
        fill(0, 0);

        $display("[TB] reset with random inputs");
        rst_n = 1'b0;
        repeat (2) begin
            dif.start     = 1'($urandom);
            dif.base_chal = 5'($urandom);
            @(negedge clk);
        end
        checkOutput("rst_busy", dif.busy, 0);
        checkOutput("rst_done", dif.done, 0);
        checkOutput("rst_valid", dif.resp_valid, 0);
        checkOutput("rst_resp", dif.response, 0);
        checkOutput("rst_tie", dif.tie_cnt, 0);
        checkOutput("rst_chal", dif.chal_out, 0);
        dif.start = 1'b0;
        rst_n     = 1'b1;
        repeat (2) @(negedge clk);

        fill(8, 16);
        run_case("fast_a", 5'd0, 1'b1, 8'hFF, 6'd0);
        check_seq("fast_a", seq0);

        fill(16, 8);
        run_case("fast_b", 5'd3, 1'b1, 8'h00, 6'd0);

        fill(0, 0);
        run_case("static", 5'd9, 1'b1, 8'h00, 6'd8);

        for (int c = 0; c < 32; c++) begin pa[c] = (c % 2 == 1) ? 6 : 24; pb[c] = 12; end
        run_case("odd_wrap", 5'd31, 1'b1, 8'h55, 6'd0);
        check_seq("odd_wrap", seq31);

`ifdef PUF_MAJORITY_EN
        fill(8, 16);
        mid_b_fast = 1'b1;
        run_case("majority", 5'($urandom), 1'b1, 8'hFF, 6'd0);
        mid_b_fast = 1'b0;
`endif

        $display("[TB] start pulses during a run");
        fill(8, 16);
        applyStimulus(1'b1, 5'd4);
        nd = 0;
        for (int e = 1; e <= LAT + 5; e++) begin
            dif.start = (e == 10) || (e == LAT - 1) || (e == LAT);
            @(negedge clk);
            if (dif.done === 1'b1) nd++;
            dif.start = 1'b0;
        end
        checkOutput("ignore_done_count", nd, 1);
        checkOutput("ignore_busy", dif.busy, 0);
        checkOutput("ignore_valid", dif.resp_valid, 1);
        checkOutput("ignore_resp", dif.response, 8'hFF);
        applyStimulus(1'b1, 5'd12);
        checkOutput("restart_valid_clear", dif.resp_valid, 0);
        checkOutput("restart_busy", dif.busy, 1);

        $display("[TB] reset in cycle 30 of a run");
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", dif.busy, 0);
        checkOutput("midrst_valid", dif.resp_valid, 0);
        checkOutput("midrst_chal", dif.chal_out, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 32; c++) begin
                int ia = $urandom_range(0, 3);
                int ib = $urandom_range(0, 3);
                if (ib == ia && ia != 0) ib = (ia + 1) % 4;
                pa[c] = opts[ia];
                pb[c] = opts[ib];
            end
            $display("[TB] random run %0d", r);
            run_case("random", 5'($urandom), 1'b0, '0, 6'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
